johnson_seq_monitor: RTL and testbench

- Downstream consumer of the 4-bit synchronous Johnson counter.
- Samples the counter's output code and its advance enable every clock.
- Decodes the code to a phase index and a one-hot phase bus.
- Checks that each sample is the legal successor, or hold, of the previous one; reports lock status and sequence errors to the rest of the design.

---
 rtl/johnson_seq_monitor_pkg.sv | 21 ++
 rtl/johnson_seq_monitor_if.sv | 30 +++
 rtl/johnson_seq_monitor_decode.sv | 32 +++
 rtl/johnson_seq_monitor.sv | 131 +++++++++++++
 tb/tb_johnson_seq_monitor.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/johnson_seq_monitor_pkg.sv
// Shared definitions for Johnson-counter consumers: monitor FSM encoding,
// default register width and the counter's successor rule.
package johnson_pkg;

  localparam int JOHNSON_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } mon_state_e;

  // Next Johnson code: shift left and feed back the inverted MSB.
  // Operates on a zero-extended code of n bits (n < 32).
  function automatic logic [31:0] succ(input logic [31:0] q, input int unsigned n);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    return ((q << 1) | {31'd0, ~q[n-1]}) & mask;
  endfunction

endpackage

// File: rtl/johnson_seq_monitor_if.sv
// Counter-sample inputs and monitor status outputs of johnson_seq_monitor.
interface johnson_seq_monitor_if
  import johnson_pkg::*;
#(
  parameter int WIDTH = JOHNSON_WIDTH,
  parameter int ERR_W = 8
);
  localparam int IDX_W = $clog2(2*WIDTH);

  logic               en;
  logic [WIDTH-1:0]   q_in;
  logic               clr_err;
  logic [IDX_W-1:0]   phase_idx;
  logic [2*WIDTH-1:0] phase_onehot;
  logic               valid_code;
  logic               locked;
  logic               seq_err;
  logic [ERR_W-1:0]   err_count;

  modport master (
    output en, q_in, clr_err,
    input  phase_idx, phase_onehot, valid_code, locked, seq_err, err_count
  );

  modport slave (
    input  en, q_in, clr_err,
    output phase_idx, phase_onehot, valid_code, locked, seq_err, err_count
  );

endinterface

// File: rtl/johnson_seq_monitor_decode.sv
// Combinational Johnson code decoder: legality flag, phase index and one-hot
// phase. Stateless so any Johnson consumer can reuse it.
module johnson_code_decode
  import johnson_pkg::*;
#(
  parameter  int WIDTH = JOHNSON_WIDTH,
  localparam int IDX_W = $clog2(2*WIDTH)
) (
  input  logic [WIDTH-1:0]   q_i,
  output logic               legal_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic [2*WIDTH-1:0] onehot_o
);

  logic [WIDTH-1:0] thermo;
  int               pop;

  // Folding 1..10..0 onto 0..01..1 lets one "low run of ones" test cover both forms.
  always_comb begin
    thermo  = q_i[WIDTH-1] ? ~q_i : q_i;
    legal_o = ((thermo & (thermo + WIDTH'(1))) == '0);
    pop     = 0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + (q_i[i] ? 1 : 0);
    end
    idx_o = IDX_W'(q_i[WIDTH-1] ? (2*WIDTH - pop) : pop);
    for (int i = 0; i < 2*WIDTH; i++) begin
      onehot_o[i] = legal_o && (int'(idx_o) == i);
    end
  end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Watches a Johnson counter's code and advance enable, tracks lock on the
// legal sequence and flags/counts sequence errors once locked.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_UNLOCK | no legal code seen yet (or last code illegal)
// ST_TRACK  | following the sequence, counting consecutive matches
// ST_LOCKED | LOCK_CNT matches seen; any deviation raises seq_err
module johnson_seq_monitor
  import johnson_pkg::*;
#(
  parameter int WIDTH    = JOHNSON_WIDTH,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  johnson_seq_monitor_if.slave mon
);

  localparam int IDX_W = $clog2(2*WIDTH);
  localparam int CNT_W = $clog2(LOCK_CNT+1);

  mon_state_e         state_q, state_d;
  logic [WIDTH-1:0]   prev_code_q;
  logic               prev_en_q;
  logic [CNT_W-1:0]   good_cnt_q, good_cnt_d;
  logic [IDX_W-1:0]   phase_idx_q, phase_idx_d;
  logic [2*WIDTH-1:0] onehot_q;
  logic               valid_q;
  logic               seq_err_q, seq_err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic               dec_legal;
  logic [IDX_W-1:0]   dec_idx;
  logic [2*WIDTH-1:0] dec_onehot;
  logic [WIDTH-1:0]   expected;
  logic               match;

  johnson_code_decode #(.WIDTH(WIDTH)) u_decode (
    .q_i      (mon.q_in),
    .legal_o  (dec_legal),
    .idx_o    (dec_idx),
    .onehot_o (dec_onehot)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_UNLOCK;
      prev_code_q <= '0;
      prev_en_q   <= 1'b0;
      good_cnt_q  <= '0;
      phase_idx_q <= '0;
      onehot_q    <= '0;
      valid_q     <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_code_q <= mon.q_in;
      prev_en_q   <= mon.en;
      good_cnt_q  <= good_cnt_d;
      phase_idx_q <= phase_idx_d;
      onehot_q    <= dec_onehot;
      valid_q     <= dec_legal;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    expected    = prev_en_q ? WIDTH'(succ(32'(prev_code_q), WIDTH)) : prev_code_q;
    match       = (mon.q_in == expected);
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    seq_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    phase_idx_d = dec_legal ? dec_idx : phase_idx_q;

    case (state_q)
      ST_UNLOCK: begin
        if (dec_legal) begin
          state_d    = ST_TRACK;
          good_cnt_d = '0;
        end
      end
      ST_TRACK: begin
        if (!dec_legal) begin
          state_d    = ST_UNLOCK;
          good_cnt_d = '0;
        end else if (!match) begin
          good_cnt_d = '0;
        end else if (int'(good_cnt_q) + 1 >= LOCK_CNT) begin
          state_d    = ST_LOCKED;
          good_cnt_d = '0;
        end else begin
          good_cnt_d = good_cnt_q + CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (!dec_legal) begin
          seq_err_d = 1'b1;
          state_d   = ST_UNLOCK;
        end else if (!match) begin
          seq_err_d  = 1'b1;
          state_d    = ST_TRACK;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_UNLOCK;
        good_cnt_d = '0;
      end
    endcase

    // A clear that coincides with a new error keeps that error visible.
    if (mon.clr_err) begin
      err_cnt_d = seq_err_d ? ERR_W'(1) : '0;
    end else if (seq_err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  assign mon.phase_idx    = phase_idx_q;
  assign mon.phase_onehot = onehot_q;
  assign mon.valid_code   = valid_q;
  assign mon.locked       = (state_q == ST_LOCKED);
  assign mon.seq_err      = seq_err_q;
  assign mon.err_count    = err_cnt_q;

endmodule

// File: tb/tb_johnson_seq_monitor.sv
// Bench for johnson_seq_monitor: directed and random counter streams checked
// against a table-driven model, on an 8-bit and a 2-bit error counter.
module tb_johnson_seq_monitor;

  logic clk;
  logic rst;

  johnson_seq_monitor_if #(.WIDTH(4), .ERR_W(8)) bus ();
  johnson_seq_monitor_if #(.WIDTH(4), .ERR_W(2)) bus_s ();

  assign bus_s.en      = bus.en;
  assign bus_s.q_in    = bus.q_in;
  assign bus_s.clr_err = bus.clr_err;

  johnson_seq_monitor #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(8)) dut (
    .clk (clk), .rst (rst), .mon (bus)
  );
  johnson_seq_monitor #(.WIDTH(4), .LOCK_CNT(4), .ERR_W(2)) dut_sat (
    .clk (clk), .rst (rst), .mon (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // legal sequence in phase order; position == phase index
  int codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  int m_prev, m_prev_en, m_mode, m_good, m_idx, m_valid, m_seqerr, m_err8, m_err2;
  int cp;

  function automatic int phase_of(input int code);
    for (int i = 0; i < 8; i++) if (codes[i] == code) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_prev_en = 0; m_mode = 0; m_good = 0;
    m_idx = 0; m_valid = 0; m_seqerr = 0; m_err8 = 0; m_err2 = 0;
  endtask

  // mode: 0 searching, 1 following, 2 locked
  task automatic model_edge(input int q, input int e, input int c);
    int ph, pp, exp_code;
    bit match;
    ph = phase_of(q);
    if (m_prev_en != 0) begin
      pp = phase_of(m_prev);
      exp_code = (pp < 0) ? -1 : codes[(pp + 1) % 8];
    end else begin
      exp_code = m_prev;
    end
    match = (q == exp_code);
    m_seqerr = 0;
    if (m_mode == 0) begin
      if (ph >= 0) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      if (ph < 0) begin m_mode = 0; m_good = 0; end
      else if (!match) m_good = 0;
      else begin
        m_good++;
        if (m_good == 4) begin m_mode = 2; m_good = 0; end
      end
    end else begin
      if (ph < 0) begin m_seqerr = 1; m_mode = 0; end
      else if (!match) begin m_seqerr = 1; m_mode = 1; m_good = 0; end
    end
    if (c != 0) begin
      m_err8 = m_seqerr; m_err2 = m_seqerr;
    end else if (m_seqerr != 0) begin
      if (m_err8 < 255) m_err8++;
      if (m_err2 < 3) m_err2++;
    end
    m_valid = (ph >= 0) ? 1 : 0;
    if (ph >= 0) m_idx = ph;
    m_prev = q; m_prev_en = e;
  endtask

  task automatic compare_all();
    logic [31:0] oh;
    oh = (m_valid != 0) ? (32'd1 << m_idx) : 32'd0;
    check("phase_idx",    32'(bus.phase_idx),    32'(m_idx));
    check("phase_onehot", 32'(bus.phase_onehot), oh);
    check("valid_code",   32'(bus.valid_code),   32'(m_valid));
    check("locked",       32'(bus.locked),       32'(m_mode == 2));
    check("seq_err",      32'(bus.seq_err),      32'(m_seqerr));
    check("err_count",    32'(bus.err_count),    32'(m_err8));
    check("err_count_w2", 32'(bus_s.err_count),  32'(m_err2));
    check("locked_w2",    32'(bus_s.locked),     32'(m_mode == 2));
  endtask

  task automatic step(input bit e, input logic [3:0] q, input bit c);
    bus.en = e; bus.q_in = q; bus.clr_err = c;
    @(posedge clk);
    model_edge(int'(q), int'(e), int'(c));
    #1;
    compare_all();
  endtask

  // behaves like the real counter: present its code, advance on en
  task automatic count_step(input bit e, input bit c);
    step(e, 4'(codes[cp]), c);
    if (e) cp = (cp + 1) % 8;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_idx"},    32'(bus.phase_idx),    32'd0);
    check({tag, "_onehot"}, 32'(bus.phase_onehot), 32'd0);
    check({tag, "_valid"},  32'(bus.valid_code),   32'd0);
    check({tag, "_locked"}, 32'(bus.locked),       32'd0);
    check({tag, "_seqerr"}, 32'(bus.seq_err),      32'd0);
    check({tag, "_errcnt"}, 32'(bus.err_count),    32'd0);
    check({tag, "_errw2"},  32'(bus_s.err_count),  32'd0);
  endtask

  initial begin
    bus.en = 1'b0; bus.q_in = 4'd0; bus.clr_err = 1'b0;
    rst = 1'b0;
    cp = 0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // acquisition from 0000, through the wrap
    for (int i = 0; i < 10; i++) begin
      count_step(1'b1, 1'b0);
      if (i == 3) check("lock_not_yet", 32'(bus.locked), 32'd0);
      if (i == 4) check("lock_5th_edge", 32'(bus.locked), 32'd1);
    end
    check("lock_after_wrap", 32'(bus.locked), 32'd1);

    // illegal code while locked
    step(1'b1, 4'b0101, 1'b0);
    check("illegal_seqerr", 32'(bus.seq_err), 32'd1);
    check("illegal_valid", 32'(bus.valid_code), 32'd0);
    check("illegal_errcnt", 32'(bus.err_count), 32'd1);
    cp = (cp + 1) % 8;
    for (int i = 0; i < 5; i++) count_step(1'b1, 1'b0);
    check("relock", 32'(bus.locked), 32'd1);

    // hold at 0111 then skip to 1110
    while (cp != 3) count_step(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) count_step(1'b0, 1'b0);
    check("hold_no_err", 32'(bus.seq_err), 32'd0);
    step(1'b1, 4'b1110, 1'b0);
    cp = 6;
    check("skip_seqerr", 32'(bus.seq_err), 32'd1);
    check("skip_errcnt", 32'(bus.err_count), 32'd2);

    // repeated lock/error cycles saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 6; i++) count_step(1'b1, 1'b0);
      step(1'b1, 4'(codes[(cp + 1) % 8]), 1'b0);
      cp = (cp + 2) % 8;
    end
    check("sat_w2", 32'(bus_s.err_count), 32'd3);
    for (int i = 0; i < 6; i++) count_step(1'b1, 1'b0);
    step(1'b1, 4'(codes[(cp + 1) % 8]), 1'b1);
    cp = (cp + 2) % 8;
    check("clr_with_err", 32'(bus.err_count), 32'd1);
    count_step(1'b1, 1'b1);
    check("clr_alone", 32'(bus.err_count), 32'd0);

    // random counter stream with occasional faults and clears
    for (int n = 0; n < 400; n++) begin
      int r;
      bit e, c;
      r = $urandom_range(0, 15);
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 24) == 0);
      if (r == 0) begin
        logic [3:0] bad;
        bad = 4'($urandom_range(0, 15));
        while (phase_of(int'(bad)) >= 0) bad = 4'($urandom_range(0, 15));
        step(e, bad, c);
      end else if (r == 1) begin
        cp = (cp + $urandom_range(2, 6)) % 8;
        count_step(e, c);
      end else begin
        count_step(e, c);
      end
    end

    // async reset mid-sequence
    for (int i = 0; i < 6; i++) count_step(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all_zero("midreset");
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      count_step(1'b1, 1'b0);
      if (i == 3) check("reacq_not_yet", 32'(bus.locked), 32'd0);
    end
    check("reacq_locked", 32'(bus.locked), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
